// File: rtl/execute_stage.sv
// EX pipeline stage: ALU, branch target, destination select and the EX/MEM register.
// Define MULT_EN to build in the shift-add multiplier with HI/LO (mult/multu/mfhi/mflo).
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  control_bits_in,
    input  logic [31:0] NPC_in,
    input  logic [31:0] reg_rs_in,
    input  logic [31:0] reg_rt_in,
    input  logic [31:0] ext_sign_in,
    input  logic [4:0]  instr_20_16_in,
    input  logic [4:0]  instr_15_11_in,
    input  logic        ex_flush,
    output logic        ex_stall,
    output logic [4:0]  mem_ctrl_out,
    output logic [31:0] branch_target_out,
    output logic        zero_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] wdata_out,
    output logic [4:0]  wreg_out
);

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;

    logic [1:0]  w_alu_op;
    logic [5:0]  w_funct;
    logic        w_rtype;
    logic        w_is_mult;
    logic        w_is_mfhilo;
    logic [31:0] w_opb;
    logic [31:0] w_alu_result;
    logic        w_stall;
    logic        w_kill_wr;

    assign w_alu_op    = control_bits_in[7:6];
    assign w_funct     = ext_sign_in[5:0];
    assign w_rtype     = (w_alu_op == 2'b10);
    assign w_is_mult   = w_rtype && ((w_funct == F_MULT) || (w_funct == F_MULTU));
    assign w_is_mfhilo = w_rtype && ((w_funct == F_MFHI) || (w_funct == F_MFLO));
    assign w_opb       = control_bits_in[5] ? ext_sign_in : reg_rt_in;

`ifdef MULT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mult_state_t;

    mult_state_t r_state;
    logic [4:0]  r_count;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic        r_neg;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_product;

    assign w_signed  = (w_funct == F_MULT);
    assign w_mag_a   = (w_signed && reg_rs_in[31]) ? 32'(-reg_rs_in) : reg_rs_in;
    assign w_mag_b   = (w_signed && reg_rt_in[31]) ? 32'(-reg_rt_in) : reg_rt_in;
    assign w_product = r_neg ? 64'(-r_acc) : r_acc;
    assign w_stall   = !reset && (((r_state == S_IDLE) && w_is_mult && !ex_flush) ||
                                  (r_state == S_BUSY));
    assign w_kill_wr = w_is_mult;

    // Multiplier control: flush overrides everything and never touches HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_neg    <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (ex_flush) begin
            r_state <= S_IDLE;
            r_count <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mult) begin
                        r_mcand  <= {32'd0, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= 64'd0;
                        r_neg    <= w_signed && (reg_rs_in[31] ^ reg_rt_in[31]);
                        r_count  <= 5'd0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= {r_mcand[62:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_count  <= r_count + 5'd1;
                    if (r_count == 5'd31) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_hi    <= w_product[63:32];
                    r_lo    <= w_product[31:0];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_stall   = 1'b0;
    assign w_kill_wr = w_is_mult || w_is_mfhilo;
`endif

    assign ex_stall = w_stall;

    // ALU: fixed add/sub for ALUOp 00/01/11, funct decode for R-type.
    always_comb begin
        w_alu_result = 32'd0;
        case (w_alu_op)
            2'b01: w_alu_result = reg_rs_in - w_opb;
            2'b10: begin
                case (w_funct)
                    F_ADD, F_ADDU: w_alu_result = reg_rs_in + w_opb;
                    F_SUB, F_SUBU: w_alu_result = reg_rs_in - w_opb;
                    F_AND:  w_alu_result = reg_rs_in & w_opb;
                    F_OR:   w_alu_result = reg_rs_in | w_opb;
                    F_XOR:  w_alu_result = reg_rs_in ^ w_opb;
                    F_NOR:  w_alu_result = ~(reg_rs_in | w_opb);
                    F_SLT:  w_alu_result = 32'($signed(reg_rs_in) < $signed(w_opb));
                    F_SLTU: w_alu_result = 32'(reg_rs_in < w_opb);
`ifdef MULT_EN
                    F_MFHI: w_alu_result = r_hi;
                    F_MFLO: w_alu_result = r_lo;
`endif
                    default: w_alu_result = 32'd0;
                endcase
            end
            default: w_alu_result = reg_rs_in + w_opb;
        endcase
    end

    // EX/MEM register; stall and flush both insert a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || ex_flush || w_stall) begin
            mem_ctrl_out      <= 5'd0;
            branch_target_out <= 32'd0;
            zero_out          <= 1'b0;
            alu_result_out    <= 32'd0;
            wdata_out         <= 32'd0;
            wreg_out          <= 5'd0;
        end else begin
            mem_ctrl_out      <= {control_bits_in[4:2], control_bits_in[1] & ~w_kill_wr,
                                  control_bits_in[0]};
            branch_target_out <= NPC_in + {ext_sign_in[29:0], 2'b00};
            zero_out          <= (w_alu_result == 32'd0);
            alu_result_out    <= w_alu_result;
            wdata_out         <= reg_rt_in;
            wreg_out          <= control_bits_in[8] ? instr_15_11_in : instr_20_16_in;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; multiplier steps run only when MULT_EN is defined.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  control_bits_in;
    logic [31:0] NPC_in;
    logic [31:0] reg_rs_in;
    logic [31:0] reg_rt_in;
    logic [31:0] ext_sign_in;
    logic [4:0]  instr_20_16_in;
    logic [4:0]  instr_15_11_in;
    logic        ex_flush;
    logic        ex_stall;
    logic [4:0]  mem_ctrl_out;
    logic [31:0] branch_target_out;
    logic        zero_out;
    logic [31:0] alu_result_out;
    logic [31:0] wdata_out;
    logic [4:0]  wreg_out;

    int errors = 0;
    int checks = 0;

    localparam logic [8:0] C_RTYPE = 9'h182;
    localparam logic [8:0] C_BEQ   = 9'h050;
    localparam logic [8:0] C_LW    = 9'h02B;

    execute_stage dut (
        .clk               (clk),
        .reset             (reset),
        .control_bits_in   (control_bits_in),
        .NPC_in            (NPC_in),
        .reg_rs_in         (reg_rs_in),
        .reg_rt_in         (reg_rt_in),
        .ext_sign_in       (ext_sign_in),
        .instr_20_16_in    (instr_20_16_in),
        .instr_15_11_in    (instr_15_11_in),
        .ex_flush          (ex_flush),
        .ex_stall          (ex_stall),
        .mem_ctrl_out      (mem_ctrl_out),
        .branch_target_out (branch_target_out),
        .zero_out          (zero_out),
        .alu_result_out    (alu_result_out),
        .wdata_out         (wdata_out),
        .wreg_out          (wreg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] ctrl, input logic [31:0] npc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ext, input logic flush);
        control_bits_in = ctrl;
        NPC_in          = npc;
        reg_rs_in       = rs;
        reg_rt_in       = rt;
        ext_sign_in     = ext;
        instr_20_16_in  = 5'd2;
        instr_15_11_in  = 5'd3;
        ex_flush        = flush;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(C_RTYPE, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h20, 1'b0);
        repeat (2) tick();
        chk("reset_alu", alu_result_out, 32'h0);
        chk("reset_ctrl", 32'(mem_ctrl_out), 32'h0);
        chk("reset_stall", 32'(ex_stall), 32'h0);
        reset = 1'b0;

        // add wraps past signed max
        drive(C_RTYPE, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h20, 1'b0);
        tick();
        chk("add_res", alu_result_out, 32'h80000000);
        chk("add_zero", 32'(zero_out), 32'h0);
        chk("add_ctrl", 32'(mem_ctrl_out), 32'h02);
        chk("add_wreg", 32'(wreg_out), 32'd3);
        chk("add_wdata", wdata_out, 32'h1);
        chk("add_bt", branch_target_out, 32'h80);

        // beq with negative offset
        drive(C_BEQ, 32'h100, 32'h5, 32'h5, 32'hFFFFFFFF, 1'b0);
        tick();
        chk("beq_zero", 32'(zero_out), 32'h1);
        chk("beq_bt", branch_target_out, 32'hFC);
        chk("beq_ctrl", 32'(mem_ctrl_out), 32'h10);
        chk("beq_wreg", 32'(wreg_out), 32'd2);

        drive(C_RTYPE, 32'h0, 32'hFFFF0000, 32'h00FF00FF, 32'h22, 1'b0); tick();
        chk("sub", alu_result_out, 32'hFEFFFF01);
        drive(C_RTYPE, 32'h0, 32'hFFFF0000, 32'h00FF00FF, 32'h24, 1'b0); tick();
        chk("and", alu_result_out, 32'h00FF0000);
        drive(C_RTYPE, 32'h0, 32'hFFFF0000, 32'h00FF00FF, 32'h25, 1'b0); tick();
        chk("or", alu_result_out, 32'hFFFF00FF);
        drive(C_RTYPE, 32'h0, 32'hFFFF0000, 32'h00FF00FF, 32'h26, 1'b0); tick();
        chk("xor", alu_result_out, 32'hFF0000FF);
        drive(C_RTYPE, 32'h0, 32'hFFFF0000, 32'h00FF00FF, 32'h27, 1'b0); tick();
        chk("nor", alu_result_out, 32'h0000FF00);
        drive(C_RTYPE, 32'h0, 32'hFFFF0000, 32'h00FF00FF, 32'h2A, 1'b0); tick();
        chk("slt", alu_result_out, 32'h1);
        drive(C_RTYPE, 32'h0, 32'hFFFF0000, 32'h00FF00FF, 32'h2B, 1'b0); tick();
        chk("sltu", alu_result_out, 32'h0);
        drive(C_RTYPE, 32'h0, 32'hFFFF0000, 32'h00FF00FF, 32'h3F, 1'b0); tick();
        chk("badfunct", alu_result_out, 32'h0);
        chk("badfunct_zero", 32'(zero_out), 32'h1);

        // lw: immediate operand, load controls pass through
        drive(C_LW, 32'h200, 32'h100, 32'h55, 32'hFFFFFFF0, 1'b0); tick();
        chk("lw_addr", alu_result_out, 32'hF0);
        chk("lw_ctrl", 32'(mem_ctrl_out), 32'h0B);
        chk("lw_bt", branch_target_out, 32'h1C0);
        chk("lw_wreg", 32'(wreg_out), 32'd2);

        drive(C_RTYPE, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h20, 1'b1); tick();
        chk("flush_alu", alu_result_out, 32'h0);
        chk("flush_ctrl", 32'(mem_ctrl_out), 32'h0);

`ifdef MULT_EN
        // mult -3 * 7
        drive(C_RTYPE, 32'h0, 32'hFFFFFFFD, 32'h7, 32'h18, 1'b0);
        chk("mult_stall0", 32'(ex_stall), 32'h1);
        n = 0;
        while (ex_stall && n < 40) begin
            tick();
            n++;
            if (n == 5) chk("mult_bubble", alu_result_out, 32'h0);
        end
        chk("mult_stall_cycles", 32'(n), 32'd33);
        tick();
        chk("mult_ctrl", 32'(mem_ctrl_out), 32'h0);
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h12, 1'b0); tick();
        chk("mflo_s", alu_result_out, 32'hFFFFFFEB);
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0); tick();
        chk("mfhi_s", alu_result_out, 32'hFFFFFFFF);
        chk("mfhi_ctrl", 32'(mem_ctrl_out), 32'h02);

        // multu of all-ones
        drive(C_RTYPE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h19, 1'b0);
        n = 0;
        while (ex_stall && n < 40) begin tick(); n++; end
        chk("multu_stall_cycles", 32'(n), 32'd33);
        tick();
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0); tick();
        chk("mfhi_u", alu_result_out, 32'hFFFFFFFE);
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h12, 1'b0); tick();
        chk("mflo_u", alu_result_out, 32'h00000001);

        // reset at BUSY count 10 aborts the multiply
        drive(C_RTYPE, 32'h0, 32'h2, 32'h3, 32'h18, 1'b0);
        repeat (11) tick();
        chk("busy_stall", 32'(ex_stall), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_busy_stall", 32'(ex_stall), 32'h0);
        chk("rst_busy_alu", alu_result_out, 32'h0);
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_mfhi", alu_result_out, 32'h0);
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h12, 1'b0); tick();
        chk("rst_mflo", alu_result_out, 32'h0);

        // load known HI/LO, then flush a later multiply mid-BUSY
        drive(C_RTYPE, 32'h0, 32'h00012345, 32'h00010000, 32'h19, 1'b0);
        n = 0;
        while (ex_stall && n < 40) begin tick(); n++; end
        tick();
        drive(C_RTYPE, 32'h0, 32'h5, 32'h6, 32'h18, 1'b0);
        repeat (5) tick();
        ex_flush = 1'b1;
        chk("flush_busy_stall", 32'(ex_stall), 32'h1);
        tick();
        chk("flush_busy_alu", alu_result_out, 32'h0);
        chk("flush_busy_ctrl", 32'(mem_ctrl_out), 32'h0);
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0);
        chk("flush_idle_stall", 32'(ex_stall), 32'h0);
        tick();
        chk("flush_mfhi", alu_result_out, 32'h1);
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h12, 1'b0); tick();
        chk("flush_mflo", alu_result_out, 32'h23450000);
`else
        drive(C_RTYPE, 32'h0, 32'hFFFFFFFD, 32'h7, 32'h18, 1'b0);
        chk("nomult_stall", 32'(ex_stall), 32'h0);
        tick();
        chk("nomult_res", alu_result_out, 32'h0);
        chk("nomult_ctrl", 32'(mem_ctrl_out), 32'h0);
        drive(C_RTYPE, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0); tick();
        chk("nomfhi_res", alu_result_out, 32'h0);
        chk("nomfhi_ctrl", 32'(mem_ctrl_out), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 control_bits_in  input  9  from ID/EX: [8]RegDst [7:6]ALUOp [5]ALUSrc [4]Branch [3]MemRead [2]MemWrite [1]RegWrite [0]MemtoReg.
REQ-005 NPC_in  input  32  PC+4 of the instruction in EX.
REQ-006 reg_rs_in, reg_rt_in  input  32 each  register operands.
REQ-007 ext_sign_in  input  32  sign-extended immediate; [5:0] is funct.
REQ-008 instr_20_16_in, instr_15_11_in  input  5 each  rt / rd fields.
REQ-009 ex_flush  input  1  synchronous kill of the instruction in EX.
REQ-010 ex_stall  output  1  upstream SHALL hold all inputs stable while high.
REQ-011 mem_ctrl_out  output  5  registered control_bits[4:0].
REQ-012 branch_target_out  output  32  registered NPC_in + (ext_sign_in << 2), modulo 2^32.
REQ-013 zero_out  output  1  registered (alu_result == 0).
REQ-014 alu_result_out  output  32  registered ALU result.
REQ-015 wdata_out  output  32  registered reg_rt_in (store data).
REQ-016 wreg_out  output  5  registered RegDst ? instr_15_11_in : instr_20_16_in.

Function
REQ-017 Operand B SHALL be ext_sign_in if ALUSrc, else reg_rt_in.
REQ-018 ALUOp 00 -> add; 01 -> sub; 11 -> add; 10 -> decode funct.
REQ-019 funct: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed), 0x2B sltu, 0x10 mfhi, 0x12 mflo, 0x18 mult, 0x19 multu; any other funct -> result 0.
REQ-020 Add/sub SHALL wrap modulo 2^32; no overflow trap.
REQ-021 Multiplier FSM states: IDLE, BUSY, DONE.
REQ-022 IDLE: if mult/multu is in EX and ex_flush=0, latch operands, clear count, go BUSY.
REQ-023 BUSY: one shift-add step per cycle; count 0..31; at count 31 go DONE.
REQ-024 DONE: write 64-bit product to HI (upper) and LO (lower) on exit; go IDLE unconditionally, without re-detecting the held mult.
REQ-025 mult SHALL multiply magnitudes and negate the product when operand signs differ; multu is unsigned.
REQ-026 ex_stall = (IDLE and mult detected and not ex_flush) or BUSY; it is low in DONE.
REQ-027 Result: 33 stall cycles; the mult leaves EX in the 34th cycle.
REQ-028 mfhi/mflo in the cycle after DONE SHALL read the new HI/LO.
REQ-029 While ex_stall=1, the EX/MEM outputs SHALL capture a bubble: mem_ctrl_out=0, data outputs 0.
REQ-030 A mult/multu leaving EX SHALL force RegWrite=0 in mem_ctrl_out.
REQ-031 ex_flush=1 SHALL capture a bubble, force the FSM to IDLE, and leave HI/LO unchanged.
REQ-032 ex_flush SHALL win over simultaneous mult detection or a BUSY/DONE state.

Reset
REQ-033 While reset is high, all registered outputs SHALL be 0, HI=LO=0, FSM=IDLE, count=0, ex_stall=0.
REQ-034 Reset mid-BUSY SHALL abort the multiply; no partial HI/LO write.

Configuration
REQ-035 Macro MULT_EN defined: multiplier, HI/LO and FSM are compiled in as specified.
REQ-036 MULT_EN undefined: funct 0x18/0x19/0x10/0x12 yield result 0 with RegWrite forced 0; ex_stall is tied 0; no HI/LO storage exists.

Verification
REQ-037 add: ALUOp=10, funct=0x20, rs=0x7FFFFFFF, rt=1 -> alu_result_out=0x80000000, zero_out=0 next edge.
REQ-038 beq: ALUOp=01, rs=rt=5, NPC=0x100, imm=0xFFFFFFFF -> zero_out=1, branch_target_out=0x000000FC.
REQ-039 mult: rs=-3, rt=7 -> ex_stall high 33 cycles; then mflo -> 0xFFFFFFEB, mfhi -> 0xFFFFFFFF.
REQ-040 multu: rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-041 reset at BUSY count 10 -> ex_stall=0 and outputs 0 immediately; subsequent mfhi -> 0.
REQ-042 ex_flush during BUSY -> bubble, FSM=IDLE, HI/LO keep prior values, ex_stall drops next cycle.
